// File: rtl/lru_victim_ctrl_if.sv
// Bundle between the replacement controller and its neighbours: miss/hit
// requesters, the per-set LRU tracker and the writeback/fill engines.
interface lru_victim_ctrl_if #(
  parameter int WIDTH      = 4,
  parameter int INDEX_BITS = 8
);
  localparam int WAY_BITS = $clog2(WIDTH);

  logic                  miss_valid;
  logic                  miss_ready;
  logic [INDEX_BITS-1:0] miss_index;
  logic [WIDTH-1:0]      way_valid;
  logic [WIDTH-1:0]      way_dirty;

  logic                  hit_valid;
  logic                  hit_ready;
  logic [INDEX_BITS-1:0] hit_index;
  logic [WAY_BITS-1:0]   hit_way;

  logic [INDEX_BITS-1:0] lru_index;
  logic [WAY_BITS-1:0]   lru_access;
  logic                  lru_access_valid;
  logic [WIDTH-1:0]      lru;

  logic                  wb_req;
  logic                  wb_ack;
  logic                  fill_req;
  logic                  fill_ack;

  logic [WAY_BITS-1:0]   victim_way;
  logic                  done;

  // Controller side.
  modport slave (
    input  miss_valid, miss_index, way_valid, way_dirty,
    input  hit_valid, hit_index, hit_way,
    input  lru, wb_ack, fill_ack,
    output miss_ready, hit_ready,
    output lru_index, lru_access, lru_access_valid,
    output wb_req, fill_req, victim_way, done
  );

  // Requester / tracker / memory side.
  modport master (
    output miss_valid, miss_index, way_valid, way_dirty,
    output hit_valid, hit_index, hit_way,
    output lru, wb_ack, fill_ack,
    input  miss_ready, hit_ready,
    input  lru_index, lru_access, lru_access_valid,
    input  wb_req, fill_req, victim_way, done
  );
endinterface

// File: rtl/lru_victim_ctrl.sv
// Replacement controller in front of the per-set LRU tracker. Misses read
// the set's LRU state, pick a victim, run an optional writeback and a fill,
// then commit the LRU touch. Hits forward a single LRU touch.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a hit (priority) or a miss
// HIT       | one-cycle LRU touch for the registered hit way
// READ      | tracker read port presenting the indexed set
// SELECT    | sample lru/valid/dirty, choose and latch the victim
// WRITEBACK | wb_req held until wb_ack
// FILL      | fill_req held until fill_ack
// UPDATE    | LRU touch for the victim, done pulse
module lru_victim_ctrl #(
  parameter int WIDTH      = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lru_victim_ctrl_if.slave ctrl_if
);
  localparam int WAY_BITS = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    READ,
    SELECT,
    WRITEBACK,
    FILL,
    UPDATE
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic [WAY_BITS-1:0]   victim_q, victim_d;

  logic [WAY_BITS-1:0]   sel_way;
  logic                  sel_found;
  logic                  sel_dirty;

  logic                  hit_ready;
  logic                  miss_ready;
  logic                  acc_valid;
  logic [WAY_BITS-1:0]   acc_way;
  logic                  wb_req;
  logic                  fill_req;
  logic                  done;

  // Victim choice: lowest invalid way, else lowest LRU-flagged way, else way 0
  // (an all-zero lru vector means the tracker is corrupt; way 0 keeps us moving).
  always_comb begin
    sel_way   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!sel_found && !ctrl_if.way_valid[i]) begin
        sel_way   = WAY_BITS'(i);
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!sel_found && ctrl_if.lru[i]) begin
        sel_way   = WAY_BITS'(i);
        sel_found = 1'b1;
      end
    end
    sel_dirty = ctrl_if.way_valid[sel_way] && ctrl_if.way_dirty[sel_way];
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    way_d      = way_q;
    victim_d   = victim_q;
    hit_ready  = 1'b0;
    miss_ready = 1'b0;
    acc_valid  = 1'b0;
    acc_way    = way_q;
    wb_req     = 1'b0;
    fill_req   = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        hit_ready  = 1'b1;
        miss_ready = !ctrl_if.hit_valid;
        if (ctrl_if.hit_valid) begin
          idx_d   = ctrl_if.hit_index;
          way_d   = ctrl_if.hit_way;
          state_d = HIT;
        end else if (ctrl_if.miss_valid) begin
          idx_d   = ctrl_if.miss_index;
          state_d = READ;
        end
      end
      HIT: begin
        acc_valid = 1'b1;
        acc_way   = way_q;
        state_d   = IDLE;
      end
      READ: begin
        state_d = SELECT;
      end
      SELECT: begin
        victim_d = sel_way;
        state_d  = sel_dirty ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        wb_req = 1'b1;
        if (ctrl_if.wb_ack) state_d = FILL;
      end
      FILL: begin
        fill_req = 1'b1;
        if (ctrl_if.fill_ack) state_d = UPDATE;
      end
      UPDATE: begin
        acc_valid = 1'b1;
        acc_way   = victim_q;
        done      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      way_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      way_q    <= way_d;
      victim_q <= victim_d;
    end
  end

  // Strobes are masked by reset so the tracker can self-initialise and an
  // aborted miss never leaves a request or LRU write hanging.
  assign ctrl_if.hit_ready        = hit_ready;
  assign ctrl_if.miss_ready       = miss_ready;
  assign ctrl_if.lru_index        = idx_q;
  assign ctrl_if.lru_access       = acc_way;
  assign ctrl_if.lru_access_valid = acc_valid && !rst_i;
  assign ctrl_if.wb_req           = wb_req && !rst_i;
  assign ctrl_if.fill_req         = fill_req && !rst_i;
  assign ctrl_if.done             = done && !rst_i;
  assign ctrl_if.victim_way       = (state_q == SELECT) ? sel_way : victim_q;
endmodule

// File: doc/lru_victim_ctrl.md
# lru_victim_ctrl

Replacement controller that sits directly upstream of the per-set LRU tracker in the L1 cache. On a miss it reads the LRU state for the indexed set, selects a victim way, sequences an optional dirty writeback and a line fill, then commits the LRU update. On a hit it forwards a single LRU touch for the hit way. It owns every write to the tracker's access port apart from the tracker's own reset initialisation.

## Interface
- WIDTH, 4: ways per set; power of two, at least 2. WAY_BITS = log2(WIDTH).
- INDEX_BITS, 8: set index width.

- clock  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high.
- miss_valid / miss_ready  in / out  1 / 1  miss request handshake.
- miss_index  in  INDEX_BITS  set of the miss; sampled at accept.
- way_valid  in  WIDTH  valid bits of the indexed set; held stable by the requester from accept to done.
- way_dirty  in  WIDTH  dirty bits of the indexed set; same stability rule.
- hit_valid / hit_ready  in / out  1 / 1  hit-touch handshake.
- hit_index  in  INDEX_BITS  set of the hit.
- hit_way  in  WAY_BITS  way of the hit.
- lru_index  out  INDEX_BITS  set address to the tracker.
- lru_access  out  WAY_BITS  way to mark most-recently-used.
- lru_access_valid  out  1  tracker write strobe.
- lru  in  WIDTH  tracker output; bit i = way i is LRU; valid one cycle after lru_index changes.
- wb_req / wb_ack  out / in  1 / 1  dirty-line writeback handshake.
- fill_req / fill_ack  out / in  1 / 1  line-fill handshake.
- victim_way  out  WAY_BITS  selected way; valid from SELECT until the next accept.
- done  out  1  one-cycle pulse when a miss completes.

## Operation
- States: IDLE, HIT, READ, SELECT, WRITEBACK, FILL, UPDATE.
- IDLE: hit_ready=1 and miss_ready=!hit_valid. A hit has priority over a miss in the same cycle.
- IDLE + hit_valid: register hit_index into idx_q and hit_way into way_q, then go to HIT. In HIT, lru_access_valid=1 and lru_access=way_q for one cycle, then return to IDLE.
- IDLE + miss_valid + miss_ready: register miss_index into idx_q, then go to READ.
- READ: a single wait cycle while the tracker's read port presents the set.
- SELECT: sample lru, way_valid and way_dirty.
  - Victim is the lowest-numbered invalid way if any way is invalid.
  - Otherwise it is the lowest-numbered way with lru[i]=1.
  - If no lru bit is set, the victim is way 0.
  - Load the victim into victim_way. Next state is WRITEBACK if the victim is valid and dirty, else FILL.
- WRITEBACK: hold wb_req=1 until wb_ack is sampled high, then go to FILL.
- FILL: hold fill_req=1 until fill_ack is sampled high, then go to UPDATE.
- UPDATE: lru_access_valid=1, lru_access=victim_way, done=1 for one cycle, then return to IDLE.
- lru_index=idx_q at all times. lru_access_valid is 0 in every state other than HIT and UPDATE.
- hit_ready=0 and miss_ready=0 whenever the state is not IDLE. Hits arriving during a miss stall.

## Timing
- Reset values:
  - state IDLE, idx_q=0, way_q=0, victim_way=0.
  - lru_access_valid=0, wb_req=0, fill_req=0, done=0.
  - hit_ready=1, miss_ready=1.
- While reset=1, lru_access_valid stays 0 so the tracker can initialise itself.
- Reset mid-miss returns the block to IDLE on the next edge. wb_req and fill_req drop in that cycle, and no done or LRU write is issued.
- Hit touch: accepted in cycle 0, lru_access_valid in cycle 1, hit_ready=1 again in cycle 2.
- Clean miss with fill_ack already high: accept c0, READ c1, SELECT c2, FILL c3, UPDATE/done c4. Minimum latency is 4 cycles.
- Dirty miss adds at least one WRITEBACK cycle: done comes at c5 or later.
- An ack sampled low extends its state by one cycle per wait cycle. A req stays asserted until the cycle in which its ack is sampled high.
- Acks arriving outside their state are ignored.
- The back-to-back miss path has one idle cycle: the next miss can be accepted in the cycle after UPDATE.

## Test plan
- Reset, then a hit with hit_index=5, hit_way=2 -> one cycle later: lru_access_valid=1, lru_index=5, lru_access=2. Nothing is written in the following cycle.
- Miss on index 9, way_valid=4'b1011, way_dirty=4'b1111, fill_ack tied high -> victim_way=2 (the invalid way wins), no wb_req, done at c4 with lru_access=2.
- Miss on index 3, all ways valid, lru=4'b1000, way_dirty[3]=1, wb_ack delayed 3 cycles -> wb_req held for 4 cycles, then FILL, then done with lru_access=3.
- hit_valid and miss_valid both asserted in IDLE -> hit_ready=1, miss_ready=0. The hit touch occurs first, and the miss is accepted after the return to IDLE.
- Reset asserted during WRITEBACK -> wb_req=0 next cycle, no done, no lru_access_valid, hit_ready=1 and miss_ready=1.
- All ways valid with lru=0 (corrupt tracker state) -> victim_way=0 and the miss completes normally.
